gx4000_asic_ram_arb: RTL and testbench

Three-way arbiter and sequencer for the single-port 16 KB ASIC register RAM (0x4000–0x7FFF window) in the GX4000/Plus core. It shares the RAM between the Z80 CPU, the sprite/palette fetch engine and the DMA sound engine. It issues one access per cycle, uses display-phase-dependent priority, and optionally applies starvation aging. It sits between the ASIC unlock/register logic and the RAM macro.

---
 rtl/gx4000_asic_ram_arb.sv | 146 ++++++++++++++
 tb/tb_gx4000_asic_ram_arb.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gx4000_asic_ram_arb.sv
// Three-way arbiter for the 16 KB Plus ASIC register RAM (cpu / sprite / DMA sound).
// Optional starvation aging is enabled by defining GX4000_ARB_AGING_EN.
module gx4000_asic_ram_arb #(
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        plus_mode,
  input  logic        disp_active,
  input  logic        cpu_req,
  input  logic        spr_req,
  input  logic        dma_req,
  input  logic        cpu_we,
  input  logic        spr_we,
  input  logic        dma_we,
  input  logic [13:0] cpu_addr,
  input  logic [13:0] spr_addr,
  input  logic [13:0] dma_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  dma_wdata,
  output logic        cpu_gnt,
  output logic        spr_gnt,
  output logic        dma_gnt,
  output logic        cpu_rvalid,
  output logic        spr_rvalid,
  output logic        dma_rvalid,
  output logic [7:0]  cpu_rdata,
  output logic [7:0]  spr_rdata,
  output logic [7:0]  dma_rdata,
  output logic [13:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_q,
  output logic [1:0]  arb_owner
);

  localparam int unsigned AW = 14;
  localparam int unsigned DW = 8;
  localparam int unsigned NP = 3;

  logic [NP-1:0] w_req;
  logic [NP-1:0] w_cand;
  logic [NP-1:0] w_pool;
  logic [NP-1:0] w_gnt;
  logic [1:0]    w_owner;
  logic [NP-1:0] r_rv;
  logic          r_cpu_ff;
  logic          w_unused;

  // Bit order everywhere: {dma, spr, cpu}
  assign w_req  = {dma_req, spr_req, cpu_req};
  assign w_cand = {dma_req & plus_mode, spr_req & plus_mode, cpu_req};

`ifdef GX4000_ARB_AGING_EN
  localparam int unsigned CW = 4;
  logic [CW-1:0] r_wait [NP];
  logic [NP-1:0] w_urg;

  always_ff @(posedge clk_sys) begin
    for (int i = 0; i < NP; i++) begin
      if (reset || !w_req[i] || w_gnt[i]) begin
        r_wait[i] <= '0;
      end else if (r_wait[i] != {CW{1'b1}}) begin
        r_wait[i] <= r_wait[i] + CW'(1);
      end
    end
  end

  always_comb begin
    w_urg = '0;
    for (int i = 0; i < NP; i++) begin
      w_urg[i] = w_cand[i] && (r_wait[i] >= CW'(MAX_WAIT));
    end
  end

  // Urgent requesters, when present, are the only ones that compete
  assign w_pool = (|w_urg) ? w_urg : w_cand;
`else
  assign w_pool = w_cand;
`endif

  assign w_unused = spr_we | (MAX_WAIT == 0);

  always_comb begin
    w_owner = 2'd0;
    if (disp_active) begin
      if (w_pool[1])      w_owner = 2'd2;
      else if (w_pool[0]) w_owner = 2'd1;
      else if (w_pool[2]) w_owner = 2'd3;
    end else begin
      if (w_pool[0])      w_owner = 2'd1;
      else if (w_pool[1]) w_owner = 2'd2;
      else if (w_pool[2]) w_owner = 2'd3;
    end
  end

  assign w_gnt     = {w_owner == 2'd3, w_owner == 2'd2, w_owner == 2'd1};
  assign cpu_gnt   = w_gnt[0];
  assign spr_gnt   = w_gnt[1];
  assign dma_gnt   = w_gnt[2];
  assign arb_owner = w_owner;

  // RAM is only touched with Plus features on; the sprite port never writes
  always_comb begin
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_din  = '0;
    if (plus_mode) begin
      case (w_owner)
        2'd1: begin
          ram_addr = cpu_addr;
          ram_we   = cpu_we;
          ram_din  = cpu_we ? cpu_wdata : DW'(0);
        end
        2'd2: ram_addr = spr_addr;
        2'd3: begin
          ram_addr = dma_addr;
          ram_we   = dma_we;
          ram_din  = dma_we ? dma_wdata : DW'(0);
        end
        default: ram_addr = AW'(0);
      endcase
    end
  end

  // Read tags; r_cpu_ff marks a cpu read granted with the RAM disabled
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_rv     <= '0;
      r_cpu_ff <= 1'b0;
    end else begin
      r_rv[0]  <= w_gnt[0] & ~cpu_we;
      r_rv[1]  <= w_gnt[1];
      r_rv[2]  <= w_gnt[2] & ~dma_we;
      r_cpu_ff <= w_gnt[0] & ~cpu_we & ~plus_mode;
    end
  end

  assign cpu_rvalid = r_rv[0];
  assign spr_rvalid = r_rv[1];
  assign dma_rvalid = r_rv[2];
  assign cpu_rdata  = r_rv[0] ? (r_cpu_ff ? 8'hFF : ram_q) : DW'(0);
  assign spr_rdata  = r_rv[1] ? ram_q : DW'(0);
  assign dma_rdata  = r_rv[2] ? ram_q : DW'(0);

endmodule

// File: tb/tb_gx4000_asic_ram_arb.sv
// Directed vector bench for gx4000_asic_ram_arb with a synchronous-read RAM model.
module tb_gx4000_asic_ram_arb;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        plus_mode = 1'b1;
  logic        disp_active = 1'b0;
  logic        cpu_req = 1'b0, spr_req = 1'b0, dma_req = 1'b0;
  logic        cpu_we = 1'b0, dma_we = 1'b0;
  logic        spr_we = 1'b1;
  logic [13:0] cpu_addr = '0, spr_addr = '0, dma_addr = '0;
  logic [7:0]  cpu_wdata = '0, dma_wdata = '0;
  logic        cpu_gnt, spr_gnt, dma_gnt;
  logic        cpu_rvalid, spr_rvalid, dma_rvalid;
  logic [7:0]  cpu_rdata, spr_rdata, dma_rdata;
  logic [13:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic [7:0]  ram_q = '0;
  logic [1:0]  arb_owner;

  logic [7:0]  mem [16384];
  int          errors = 0;
  int          checks = 0;

  gx4000_asic_ram_arb #(.MAX_WAIT(8)) dut (
    .clk_sys(clk_sys), .reset(reset), .plus_mode(plus_mode), .disp_active(disp_active),
    .cpu_req(cpu_req), .spr_req(spr_req), .dma_req(dma_req),
    .cpu_we(cpu_we), .spr_we(spr_we), .dma_we(dma_we),
    .cpu_addr(cpu_addr), .spr_addr(spr_addr), .dma_addr(dma_addr),
    .cpu_wdata(cpu_wdata), .dma_wdata(dma_wdata),
    .cpu_gnt(cpu_gnt), .spr_gnt(spr_gnt), .dma_gnt(dma_gnt),
    .cpu_rvalid(cpu_rvalid), .spr_rvalid(spr_rvalid), .dma_rvalid(dma_rvalid),
    .cpu_rdata(cpu_rdata), .spr_rdata(spr_rdata), .dma_rdata(dma_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_q(ram_q),
    .arb_owner(arb_owner)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_q <= mem[ram_addr];
  end

  typedef struct {
    logic [2:0]  ctl;     // {reset, plus_mode, disp_active}
    logic [1:0]  cpu;     // {req, we}
    logic [13:0] caddr;
    logic [7:0]  cwd;
    logic        sreq;
    logic [13:0] saddr;
    logic [1:0]  dma;     // {req, we}
    logic [13:0] daddr;
    logic [7:0]  dwd;
    logic [2:0]  egnt;    // {dma, spr, cpu}
    logic [2:0]  erv;     // {dma, spr, cpu}
    logic [7:0]  ecd, esd, edd;
    logic        ewe;
    logic [13:0] eaddr;
    logic [7:0]  edin;
    logic [1:0]  eown;
  } vec_t;

  localparam int NV = 18;
  vec_t tv [NV];

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got %h, expected %h", nm, row, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_req = 1'b0; spr_req = 1'b0; dma_req = 1'b0;
    cpu_we = 1'b0; dma_we = 1'b0;
    cpu_addr = '0; spr_addr = '0; dma_addr = '0;
    cpu_wdata = '0; dma_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  int first_dma;
  int first_cpu;
  int spr_cnt;

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h0010] = 8'hA5;
    mem[14'h0200] = 8'h5A;

    //        ctl     cpu    caddr     cwd    sreq  saddr     dma    daddr     dwd    egnt    erv     ecd    esd    edd    ewe   eaddr     edin   eown
    tv[0]  = '{3'b110, 2'b00, 14'h0000, 8'h00, 1'b0, 14'h0000, 2'b00, 14'h0000, 8'h00, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 14'h0000, 8'h00, 2'd0};
    tv[1]  = '{3'b010, 2'b10, 14'h0010, 8'h00, 1'b0, 14'h0000, 2'b00, 14'h0000, 8'h00, 3'b001, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 14'h0010, 8'h00, 2'd1};
    tv[2]  = '{3'b010, 2'b00, 14'h0000, 8'h00, 1'b0, 14'h0000, 2'b00, 14'h0000, 8'h00, 3'b000, 3'b001, 8'hA5, 8'h00, 8'h00, 1'b0, 14'h0000, 8'h00, 2'd0};
    tv[3]  = '{3'b011, 2'b10, 14'h0010, 8'h00, 1'b1, 14'h0200, 2'b00, 14'h0000, 8'h00, 3'b010, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 14'h0200, 8'h00, 2'd2};
    tv[4]  = '{3'b011, 2'b10, 14'h0010, 8'h00, 1'b0, 14'h0000, 2'b00, 14'h0000, 8'h00, 3'b001, 3'b010, 8'h00, 8'h5A, 8'h00, 1'b0, 14'h0010, 8'h00, 2'd1};
    tv[5]  = '{3'b010, 2'b10, 14'h0010, 8'h00, 1'b1, 14'h0200, 2'b00, 14'h0000, 8'h00, 3'b001, 3'b001, 8'hA5, 8'h00, 8'h00, 1'b0, 14'h0010, 8'h00, 2'd1};
    tv[6]  = '{3'b010, 2'b00, 14'h0000, 8'h00, 1'b1, 14'h0200, 2'b00, 14'h0000, 8'h00, 3'b010, 3'b001, 8'hA5, 8'h00, 8'h00, 1'b0, 14'h0200, 8'h00, 2'd2};
    tv[7]  = '{3'b010, 2'b11, 14'h2000, 8'h3C, 1'b0, 14'h0000, 2'b00, 14'h0000, 8'h00, 3'b001, 3'b010, 8'h00, 8'h5A, 8'h00, 1'b1, 14'h2000, 8'h3C, 2'd1};
    tv[8]  = '{3'b010, 2'b00, 14'h0000, 8'h00, 1'b0, 14'h0000, 2'b10, 14'h2000, 8'h77, 3'b100, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 14'h2000, 8'h00, 2'd3};
    tv[9]  = '{3'b010, 2'b00, 14'h0000, 8'h00, 1'b0, 14'h0000, 2'b00, 14'h0000, 8'h00, 3'b000, 3'b100, 8'h00, 8'h00, 8'h3C, 1'b0, 14'h0000, 8'h00, 2'd0};
    tv[10] = '{3'b010, 2'b10, 14'h0010, 8'h00, 1'b0, 14'h0000, 2'b11, 14'h0300, 8'h11, 3'b001, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 14'h0010, 8'h00, 2'd1};
    tv[11] = '{3'b010, 2'b00, 14'h0000, 8'h00, 1'b0, 14'h0000, 2'b11, 14'h0300, 8'h11, 3'b100, 3'b001, 8'hA5, 8'h00, 8'h00, 1'b1, 14'h0300, 8'h11, 2'd3};
    tv[12] = '{3'b010, 2'b00, 14'h0000, 8'h00, 1'b0, 14'h0000, 2'b00, 14'h0000, 8'h00, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 14'h0000, 8'h00, 2'd0};
    tv[13] = '{3'b000, 2'b10, 14'h0100, 8'h00, 1'b1, 14'h0200, 2'b00, 14'h0000, 8'h00, 3'b001, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 14'h0000, 8'h00, 2'd1};
    tv[14] = '{3'b000, 2'b11, 14'h0100, 8'h99, 1'b1, 14'h0200, 2'b00, 14'h0000, 8'h00, 3'b001, 3'b001, 8'hFF, 8'h00, 8'h00, 1'b0, 14'h0000, 8'h00, 2'd1};
    tv[15] = '{3'b000, 2'b00, 14'h0000, 8'h00, 1'b1, 14'h0200, 2'b00, 14'h0000, 8'h00, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 14'h0000, 8'h00, 2'd0};
    tv[16] = '{3'b010, 2'b10, 14'h0300, 8'h00, 1'b0, 14'h0000, 2'b00, 14'h0000, 8'h00, 3'b001, 3'b000, 8'h00, 8'h00, 8'h00, 1'b0, 14'h0300, 8'h00, 2'd1};
    tv[17] = '{3'b000, 2'b00, 14'h0000, 8'h00, 1'b0, 14'h0000, 2'b00, 14'h0000, 8'h00, 3'b000, 3'b001, 8'h11, 8'h00, 8'h00, 1'b0, 14'h0000, 8'h00, 2'd0};

    reset = 1'b1;
    idle_inputs();
    step();
    step();

    for (int r = 0; r < NV; r++) begin
      {reset, plus_mode, disp_active} = tv[r].ctl;
      {cpu_req, cpu_we} = tv[r].cpu;
      cpu_addr = tv[r].caddr;  cpu_wdata = tv[r].cwd;
      spr_req = tv[r].sreq;    spr_addr = tv[r].saddr;
      {dma_req, dma_we} = tv[r].dma;
      dma_addr = tv[r].daddr;  dma_wdata = tv[r].dwd;
      @(negedge clk_sys);
      chk("gnt", r, 32'({dma_gnt, spr_gnt, cpu_gnt}), 32'(tv[r].egnt));
      chk("rvalid", r, 32'({dma_rvalid, spr_rvalid, cpu_rvalid}), 32'(tv[r].erv));
      chk("cpu_rdata", r, 32'(cpu_rdata), 32'(tv[r].ecd));
      chk("spr_rdata", r, 32'(spr_rdata), 32'(tv[r].esd));
      chk("dma_rdata", r, 32'(dma_rdata), 32'(tv[r].edd));
      chk("ram_bus", r, 32'({ram_we, ram_addr, ram_din}), 32'({tv[r].ewe, tv[r].eaddr, tv[r].edin}));
      chk("arb_owner", r, 32'(arb_owner), 32'(tv[r].eown));
      step();
    end

    // Sprite held for 20 cycles with the RAM disabled is never granted
    plus_mode = 1'b0;
    idle_inputs();
    spr_req = 1'b1; spr_addr = 14'h0200;
    spr_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_sys);
      if (spr_gnt) spr_cnt++;
      step();
    end
    chk("spr_gnt_plus_off", 100, 32'(spr_cnt), 32'd0);
    idle_inputs();
    plus_mode = 1'b1;
    step();

    // Starvation: all three request continuously during active display
    disp_active = 1'b1;
    cpu_req = 1'b1; cpu_addr = 14'h0010;
    spr_req = 1'b1; spr_addr = 14'h0200;
    dma_req = 1'b1; dma_addr = 14'h0300;
    first_dma = 0;
    first_cpu = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk_sys);
      if (dma_gnt && first_dma == 0) first_dma = c;
      if (cpu_gnt && first_cpu == 0) first_cpu = c;
      step();
    end
`ifdef GX4000_ARB_AGING_EN
    chk("first_cpu_gnt_cycle", 101, 32'(first_cpu), 32'd9);
    chk("first_dma_gnt_cycle", 102, 32'(first_dma), 32'd10);
`else
    chk("first_cpu_gnt_cycle", 101, 32'(first_cpu), 32'd0);
    chk("first_dma_gnt_cycle", 102, 32'(first_dma), 32'd0);
`endif
    idle_inputs();
    disp_active = 1'b0;
    step();

    // Reset lands the cycle after a sprite read grant
    spr_req = 1'b1; spr_addr = 14'h0200;
    @(negedge clk_sys);
    chk("spr_gnt_pre_reset", 103, 32'({dma_gnt, spr_gnt, cpu_gnt}), 32'b010);
    step();
    idle_inputs();
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h3FFF; cpu_wdata = 8'h42;
    @(negedge clk_sys);
    chk("write_during_reset", 104, 32'({ram_we, ram_addr, ram_din}), 32'({1'b1, 14'h3FFF, 8'h42}));
    step();
    idle_inputs();
    @(negedge clk_sys);
    chk("reset_rvalid", 105, 32'({dma_rvalid, spr_rvalid, cpu_rvalid}), 32'd0);
    chk("reset_rdata", 106, 32'({cpu_rdata, spr_rdata, dma_rdata}), 32'd0);
    chk("reset_ram_bus", 107, 32'({ram_we, ram_addr, ram_din, arb_owner}), 32'd0);
    step();
    reset = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
